// File: rtl/vec_add_pipe.sv
// vec_add_pipe: pipelined, element-wise integer add/sub for the vector unit.
// The WIDTH-bit carry chain is cut into NSEG segments of SW = WIDTH/NSEG bits.
// Segment k is evaluated in stage k. Its carry-out is registered with the beat
// and consumed by stage k+1 one cycle later. Element width (8/16/32/64) and
// add/sub are selected per beat. All stages advance together.
//
// Ports (top):
//   clk_i, rst_i              clock, synchronous active-high reset
//   in_valid_i / in_ready_o   operand beat handshake (in_ready_o = advance)
//   a_i, b_i                  operands
//   sub_i                     0: A+B, 1: A-B
//   sew_i                     element width 00=8, 01=16, 10=32, 11=64
//   out_valid_o / out_ready_i result handshake
//   sum_o                     element-wise result
//   carry_o                   carry-out of element j at bit j (upper bits 0)
//
// Sub-module vec_add_seg: one SW-bit slice of the chain (combinational).
//   i_a, i_b, i_sub, i_sew    slice operands and beat mode
//   i_cin                     carry into the slice LSB (from the previous stage)
//   o_s                       slice sum
//   o_cb                      carry out of each byte MSB in the slice
//   o_cout                    carry out of the slice MSB
// NSEG must be >= 2.

module vec_add_seg #(
  parameter int SW   = 16,
  parameter int BASE = 0
) (
  input  logic [SW-1:0]   i_a,
  input  logic [SW-1:0]   i_b,
  input  logic            i_sub,
  input  logic [1:0]      i_sew,
  input  logic            i_cin,
  output logic [SW-1:0]   o_s,
  output logic [SW/8-1:0] o_cb,
  output logic            o_cout
);
  logic [SW-1:0] w_bx, w_p, w_g;
  logic [31:0]   w_emask;
  logic          w_c;

  assign w_bx    = i_sub ? ~i_b : i_b;
  assign w_p     = i_a ^ w_bx;
  assign w_g     = i_a & w_bx;
  assign w_emask = (32'd8 << i_sew) - 32'd1;

  // Elements are at least one byte, so an element LSB can only fall on a
  // byte start. There the incoming carry is killed and replaced by the
  // element carry-in (1 for two's-complement subtract).
  always_comb begin
    w_c    = i_cin;
    o_s    = '0;
    o_cb   = '0;
    for (int j = 0; j < SW/8; j++) begin
      if (((BASE + 8*j) & w_emask) == 32'd0) w_c = i_sub;
      for (int i = 0; i < 8; i++) begin
        o_s[8*j+i] = w_p[8*j+i] ^ w_c;
        w_c        = w_g[8*j+i] | (w_p[8*j+i] & w_c);
      end
      o_cb[j] = w_c;
    end
    o_cout = w_c;
  end
endmodule

module vec_add_pipe #(
  parameter int WIDTH = 64,
  parameter int NSEG  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               sub_i,
  input  logic [1:0]         sew_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [WIDTH-1:0]   sum_o,
  output logic [WIDTH/8-1:0] carry_o
);
  localparam int SW = WIDTH / NSEG;
  localparam int NB = WIDTH / 8;
  localparam int SB = SW / 8;

  logic w_adv, w_acc;

  // Stage registers 0..NSEG-2. The last stage register is r_sum/r_carry.
  logic [NSEG-1:0]             r_vld_pipe;
  logic [NSEG-2:0][WIDTH-1:0]  r_a, r_b, r_s;
  logic [NSEG-2:0][NB-1:0]     r_cb;
  logic [NSEG-2:0]             r_sub, r_c;
  logic [NSEG-2:0][1:0]        r_sew;
  logic [WIDTH-1:0]            r_sum;
  logic [NB-1:0]               r_carry;

  // Per-segment slice inputs and outputs.
  logic [NSEG-1:0][SW-1:0]     w_sa, w_sb, w_ss;
  logic [NSEG-1:0]             w_ssub, w_scin, w_scout;
  logic [NSEG-1:0][1:0]        w_ssew;
  logic [NSEG-1:0][SB-1:0]     w_scb;

  logic [WIDTH-1:0]            w_sum_fin;
  logic [NB-1:0]               w_cb_fin, w_carry_fin;
  logic [1:0]                  w_fsew;

  // Full-pipe stall: nothing moves while the output is held.
  assign w_adv      = !r_vld_pipe[NSEG-1] || out_ready_i;
  assign w_acc      = in_valid_i && w_adv;
  assign in_ready_o = w_adv;

  for (genvar k = 0; k < NSEG; k++) begin : gen_seg
    if (k == 0) begin : g_in
      assign w_sa[0]   = a_i[SW-1:0];
      assign w_sb[0]   = b_i[SW-1:0];
      assign w_ssub[0] = sub_i;
      assign w_ssew[0] = sew_i;
      assign w_scin[0] = 1'b0;   // bit 0 is always an element LSB
    end else begin : g_pipe
      assign w_sa[k]   = r_a[k-1][k*SW +: SW];
      assign w_sb[k]   = r_b[k-1][k*SW +: SW];
      assign w_ssub[k] = r_sub[k-1];
      assign w_ssew[k] = r_sew[k-1];
      assign w_scin[k] = r_c[k-1];
    end

    vec_add_seg #(.SW(SW), .BASE(k*SW)) u_seg (
      .i_a    (w_sa[k]),
      .i_b    (w_sb[k]),
      .i_sub  (w_ssub[k]),
      .i_sew  (w_ssew[k]),
      .i_cin  (w_scin[k]),
      .o_s    (w_ss[k]),
      .o_cb   (w_scb[k]),
      .o_cout (w_scout[k])
    );
  end

  // Merge the top slice into the partial sum / byte carries from below.
  always_comb begin
    w_sum_fin = r_s[NSEG-2];
    w_sum_fin[(NSEG-1)*SW +: SW] = w_ss[NSEG-1];
    w_cb_fin = r_cb[NSEG-2];
    w_cb_fin[(NSEG-1)*SB +: SB] = w_scb[NSEG-1];
  end

  assign w_fsew = r_sew[NSEG-2];

  // Element j's carry is the carry out of its MSB byte; elements that do not
  // exist at the current width report 0.
  for (genvar j = 0; j < NB; j++) begin : gen_cmap
    logic w_c16, w_c32, w_c64;
    if (j < NB/2) begin : g16
      assign w_c16 = w_cb_fin[2*j+1];
    end else begin : g16z
      assign w_c16 = 1'b0;
    end
    if (j < NB/4) begin : g32
      assign w_c32 = w_cb_fin[4*j+3];
    end else begin : g32z
      assign w_c32 = 1'b0;
    end
    if (j < NB/8) begin : g64
      assign w_c64 = w_cb_fin[8*j+7];
    end else begin : g64z
      assign w_c64 = 1'b0;
    end
    assign w_carry_fin[j] = (w_fsew == 2'd0) ? w_cb_fin[j] :
                            (w_fsew == 2'd1) ? w_c16 :
                            (w_fsew == 2'd2) ? w_c32 : w_c64;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_pipe <= '0;
      r_sum      <= '0;
      r_carry    <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[NSEG-2:0], w_acc};
      r_a[0]     <= a_i;
      r_b[0]     <= b_i;
      r_sub[0]   <= sub_i;
      r_sew[0]   <= sew_i;
      r_c[0]     <= w_scout[0];
      r_s[0]     <= WIDTH'(w_ss[0]);
      r_cb[0]    <= NB'(w_scb[0]);
      for (int k = 1; k < NSEG-1; k++) begin
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_sub[k] <= r_sub[k-1];
        r_sew[k] <= r_sew[k-1];
        r_c[k]   <= w_scout[k];
        r_s[k]   <= r_s[k-1];
        r_s[k][k*SW +: SW]  <= w_ss[k];
        r_cb[k]  <= r_cb[k-1];
        r_cb[k][k*SB +: SB] <= w_scb[k];
      end
      r_sum   <= w_sum_fin;
      r_carry <= w_carry_fin;
    end
  end

  assign out_valid_o = r_vld_pipe[NSEG-1];
  assign sum_o       = r_sum;
  assign carry_o     = r_carry;

  // Operand bits already consumed by the last stage, and the final
  // carry-out (element carries come from the byte carries).
  logic w_unused;
  assign w_unused = ^{w_scout[NSEG-1],
                      r_a[NSEG-2][(NSEG-1)*SW-1:0],
                      r_b[NSEG-2][(NSEG-1)*SW-1:0]};
endmodule

// File: tb/tb_vec_add_pipe.sv
// Bench for vec_add_pipe: directed vectors, scoreboard queue filled by the
// driver on accept, drained by a negedge monitor on each output handshake.
module tb_vec_add_pipe;
  localparam int WIDTH = 64;
  localparam int NSEG  = 4;
  localparam int NB    = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_i, in_valid_i, in_ready_o, sub_i, out_valid_o, out_ready_i;
  logic [WIDTH-1:0] a_i, b_i, sum_o;
  logic [1:0]       sew_i;
  logic [NB-1:0]    carry_o;

  always #5 clk = ~clk;

  vec_add_pipe #(.WIDTH(WIDTH), .NSEG(NSEG)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .sew_i(sew_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .sum_o(sum_o), .carry_o(carry_o)
  );

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic [NB-1:0]    c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pop on each output handshake, check hold while stalled.
  initial begin
    logic             stall_q;
    logic [WIDTH-1:0] st_s;
    logic [NB-1:0]    st_c;
    exp_t             e;
    stall_q = 1'b0;
    st_s    = '0;
    st_c    = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin
        stall_q = 1'b0;
      end else begin
        chk("in_ready", 64'(in_ready_o), 64'(!(out_valid_o && !out_ready_i)));
        if (stall_q) begin
          chk("stall_valid_hold", 64'(out_valid_o), 64'd1);
          chk("stall_sum_hold", sum_o, st_s);
          chk("stall_carry_hold", 64'(carry_o), 64'(st_c));
        end
        if (out_valid_o && out_ready_i) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got sum %h, expected no result", sum_o);
          end else begin
            e = q.pop_front();
            chk("sum", sum_o, e.s);
            chk("carry", 64'(carry_o), 64'(e.c));
          end
        end
        stall_q = out_valid_o && !out_ready_i;
        st_s    = sum_o;
        st_c    = carry_o;
      end
    end
  end

  // Present one beat; returns 1ns after the accepting edge.
  task automatic send(input logic [63:0] a, input logic [63:0] b, input logic sub,
                      input logic [1:0] sew, input logic [63:0] es, input logic [7:0] ec);
    logic rdy;
    int   n;
    exp_t e;
    n = 0;
    in_valid_i = 1'b1;
    a_i = a; b_i = b; sub_i = sub; sew_i = sew;
    forever begin
      @(negedge clk);
      rdy = in_ready_o;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no accept in 50 cycles, expected accept");
        break;
      end
    end
    if (rdy) begin
      e.s = es;
      e.c = ec;
      q.push_back(e);
    end
    #1;
  endtask

  // Count edges from the accept edge until out_valid_o is seen.
  task automatic latency(input string name);
    int n;
    n = 0;
    in_valid_i = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid_o || n > 20) break;
      @(posedge clk);
      n++;
    end
    chk(name, 64'(n), 64'(NSEG-1));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; sub_i = 1'b0; sew_i = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_sum", sum_o, 64'd0);
    chk("rst_carry", 64'(carry_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    @(posedge clk); #1;

    // Carry ripples through all four segments.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b11, 64'd0, 8'h01);
    latency("latency_sew64");
    drain("drain_t1");
    @(posedge clk); #1;

    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 2'b00, 64'hFFFF_FFFF_FFFF_FF00, 8'h01);
    send(64'h00000005_00000003, 64'h00000001_00000004, 1'b1, 2'b10,
         64'h00000004_FFFFFFFF, 8'h02);
    send(64'h7FFF_7FFF_7FFF_7FFF, 64'h0001_0001_0001_0001, 1'b0, 2'b01,
         64'h8000_8000_8000_8000, 8'h00);
    in_valid_i = 1'b0;
    drain("drain_vectors");
    @(posedge clk); #1;

    // Back-to-back mixed beats while the consumer toggles ready.
    fork
      begin
        send(64'h0102_0304_0506_0708, 64'h0101_0101_0101_0101, 1'b1, 2'b00,
             64'h0001_0203_0405_0607, 8'hFF);
        send(64'd0, 64'd1, 1'b1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        send(64'hFFFF_0001_8000_1234, 64'h0001_FFFF_8000_0001, 1'b0, 2'b01,
             64'h0000_0000_0000_1235, 8'h0E);
        send(64'h8000_0000_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 2'b10,
             64'd0, 8'h03);
        send(64'h0000_0000_0000_80FF, 64'h0000_0000_0000_8001, 1'b0, 2'b00,
             64'd0, 8'h03);
        send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 2'b11,
             64'h0000_0001_0000_0000, 8'h00);
        in_valid_i = 1'b0;
      end
      begin
        repeat (24) begin
          @(posedge clk); #1 out_ready_i = ~out_ready_i;
        end
        out_ready_i = 1'b1;
      end
    join
    drain("drain_b2b");
    @(posedge clk); #1;

    // Reset with three beats in flight: all of them must vanish.
    send(64'h1111, 64'h2222, 1'b0, 2'b11, 64'h3333, 8'h00);
    send(64'h4444, 64'h1111, 1'b1, 2'b11, 64'h3333, 8'h01);
    send(64'h0F0F, 64'h0101, 1'b0, 2'b00, 64'h1010, 8'h00);
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    q.delete();
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    chk("flush_sum", sum_o, 64'd0);
    chk("flush_carry", 64'(carry_o), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    send(64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 2'b01,
         64'h0100_0100_0100_0100, 8'h00);
    latency("latency_after_reset");
    drain("drain_after_reset");
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/vec_add_pipe.md
Name: vec_add_pipe

Overview:
- Parametrised, pipelined, multi-element integer adder/subtractor for the vector unit.
- Successor to the single-cycle P^C sum stage: splits a WIDTH-bit carry chain across NSEG registered segments and adds selectable element width (SEW) and add/sub mode.
- Adds a valid/ready handshake with full-pipe stall.
- Sits between the vector operand read stage and the writeback arbiter.

Parameters:
- WIDTH, 64, datapath width in bits; multiple of 64.
- NSEG, 4, pipeline segments (= latency); WIDTH/NSEG must be a multiple of 8.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- in_valid_i  input  1  operand beat valid
- in_ready_o  output  1  block accepts beat this cycle
- a_i  input  WIDTH  operand A
- b_i  input  WIDTH  operand B
- sub_i  input  1  0 = A+B, 1 = A-B
- sew_i  input  2  element width: 00 = 8, 01 = 16, 10 = 32, 11 = 64 bits
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- sum_o  output  WIDTH  element-wise result
- carry_o  output  WIDTH/8  carry-out of element j at bit j; bits at or above WIDTH/SEW are 0

Behaviour:
- Reset: one clock is fixed; reset is synchronous and active-high (rst_i sampled on rising clk_i).
  - All stage valids, out_valid_o, sum_o and carry_o are cleared to 0.
  - in_ready_o = 1 in the first cycle after reset release.
- Segment width SW = WIDTH/NSEG.
  - Stage k (0..NSEG-1) computes bits [k*SW +: SW] using P = A^B', G = A&B', S = P^C.
  - B' = sub ? ~B : B.
- Carry-in at each element's LSB:
  - add: 0
  - sub: 1 (two's complement)
- At bit positions inside an element, the carry ripples normally.
- At an element boundary, the carry is killed, including at segment boundaries.
- Inter-segment carry is registered with the beat and consumed by the next stage one cycle later.
- Operand skew: the not-yet-used upper operand bits, sub, sew and the computed lower sum bits travel with the beat through the stage registers.
- carry_o[j] = carry out of the MSB of element j.
  - For sub, 1 means no borrow (A >= B unsigned).
- Pipeline advance: adv = !out_valid_o || out_ready_i.
  - All stages shift together when adv = 1 and hold otherwise (full stall, no bubble collapse).
  - in_ready_o = adv (combinational).
- A beat is accepted when in_valid_i && in_ready_o.
- Latency: a beat accepted at edge t produces out_valid_o = 1 after edge t+NSEG-1, i.e. NSEG stage registers including the output register.
  - Throughput is 1 beat/cycle while out_ready_i = 1.
- Output stability:
  - While out_valid_o && !out_ready_i, sum_o and carry_o hold stable.
  - When out_valid_o = 0, sum_o and carry_o hold their last value and are don't-care.
- Ordering: results leave strictly in acceptance order; no drop, no duplication.
- Simultaneous output handshake and input accept with a full pipe is legal and sustains 1 beat/cycle.
- Reset mid-operation: every in-flight beat is discarded.
  - No stale result appears after reset release.
- sew_i and sub_i are per beat; mixed modes back-to-back are legal.

Test Plan:
- SEW=11, add, a=64'hFFFF_FFFF_FFFF_FFFF, b=1 -> sum_o=0, carry_o=8'h01, out_valid_o rises NSEG cycles after accept (carry crosses all 4 segments).
- SEW=00, add, same operands -> sum_o=64'hFFFF_FFFF_FFFF_FF00, carry_o=8'h01.
- SEW=10, sub, a=64'h00000005_00000003, b=64'h00000001_00000004 -> sum_o=64'h00000004_FFFFFFFF, carry_o=8'h02.
- SEW=01, add, a=64'h7FFF_7FFF_7FFF_7FFF, b=64'h0001_0001_0001_0001 -> sum_o=64'h8000_8000_8000_8000, carry_o=8'h00.
- 6 back-to-back beats with mixed sew/sub, out_ready_i toggling 1,0,1,0 -> results in order, none lost or duplicated, in_ready_o=0 exactly when out_valid_o && !out_ready_i, sum_o stable while stalled.
- rst_i asserted for 1 cycle with 3 beats in flight -> out_valid_o=0 next cycle, no old result after release, a new beat then emerges after NSEG cycles.
